// File: rtl/uart_tx_fifo.sv
// UART transmitter with an 8-entry transmit FIFO and per-frame configuration
// (5-8 data bits, none/even/odd parity, 1 or 2 stop bits, programmable divisor).
module uart_tx_fifo #(
  parameter int unsigned DIV_W   = 16,
  parameter int unsigned FIFO_AW = 3
) (
  input  logic                 i_clk,
  input  logic                 i_rst_n,
  input  logic [DIV_W-1:0]     i_div,
  input  logic [1:0]           i_data_bits,
  input  logic [1:0]           i_parity,
  input  logic                 i_stop2,
  input  logic                 i_tx_en,
  input  logic                 i_wr,
  input  logic [7:0]           i_byte,
  output logic                 o_full,
  output logic                 o_empty,
  output logic [FIFO_AW:0]     o_count,
  output logic                 o_overflow,
  output logic                 o_busy,
  output logic                 o_complete,
  output logic                 o_tx_serial
);

  localparam int unsigned DEPTH = 2 ** FIFO_AW;
  localparam int unsigned CW    = FIFO_AW + 1;

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

  state_t             state_q, state_d;
  logic [DIV_W-1:0]   cnt_q, cnt_d;
  logic [DIV_W-1:0]   div_q;
  logic [2:0]         last_idx_q;
  logic [2:0]         bit_idx_q, bit_idx_d;
  logic [7:0]         shreg_q, shreg_d;
  logic               par_en_q, par_bit_q, stop2_q;
  logic               stop_idx_q, stop_idx_d;
  logic               tx_q, tx_d, busy_q, complete_q, overflow_q;
  logic               pop, push, done, boundary;

  logic [7:0]         mem [DEPTH];
  logic [FIFO_AW-1:0] wr_ptr_q, rd_ptr_q;
  logic [CW-1:0]      count_q, count_d;
  logic               full_q, empty_q;

  logic [DIV_W-1:0]   div_eff;
  logic [7:0]         head_masked;

  assign push        = i_wr && !full_q;
  assign div_eff     = (i_div < DIV_W'(2)) ? DIV_W'(2) : i_div;
  assign head_masked = mem[rd_ptr_q] & (8'hFF >> (2'd3 - i_data_bits));
  assign boundary    = (cnt_q == div_q - DIV_W'(1));

  // Next-state, bit timing and next line value
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    bit_idx_d  = bit_idx_q;
    shreg_d    = shreg_q;
    stop_idx_d = stop_idx_q;
    pop        = 1'b0;
    done       = 1'b0;
    tx_d       = 1'b1;

    if (state_q != IDLE) begin
      cnt_d = boundary ? '0 : cnt_q + DIV_W'(1);
    end

    case (state_q)
      IDLE: begin
        if (i_tx_en && !empty_q) begin
          pop     = 1'b1;
          shreg_d = mem[rd_ptr_q];
          cnt_d   = '0;
          state_d = START;
        end
      end
      START: begin
        if (boundary) begin
          bit_idx_d = '0;
          state_d   = DATA;
        end
      end
      DATA: begin
        if (boundary) begin
          shreg_d = shreg_q >> 1;
          if (bit_idx_q == last_idx_q) begin
            stop_idx_d = 1'b0;
            state_d    = par_en_q ? PARITY : STOP;
          end else begin
            bit_idx_d = bit_idx_q + 3'd1;
          end
        end
      end
      PARITY: begin
        if (boundary) begin
          stop_idx_d = 1'b0;
          state_d    = STOP;
        end
      end
      STOP: begin
        if (boundary) begin
          if (stop2_q && !stop_idx_q) begin
            stop_idx_d = 1'b1;
          end else begin
            done    = 1'b1;
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase

    case (state_d)
      START:   tx_d = 1'b0;
      DATA:    tx_d = shreg_d[0];
      PARITY:  tx_d = par_bit_q;
      default: tx_d = 1'b1;
    endcase
  end

  // FIFO occupancy after this cycle's write/pop
  always_comb begin
    count_d = count_q;
    case ({push, pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      div_q      <= DIV_W'(2);
      last_idx_q <= 3'd7;
      bit_idx_q  <= '0;
      shreg_q    <= '0;
      par_en_q   <= 1'b0;
      par_bit_q  <= 1'b0;
      stop2_q    <= 1'b0;
      stop_idx_q <= 1'b0;
      tx_q       <= 1'b1;
      busy_q     <= 1'b0;
      complete_q <= 1'b0;
      overflow_q <= 1'b0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      full_q     <= 1'b0;
      empty_q    <= 1'b1;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      bit_idx_q  <= bit_idx_d;
      shreg_q    <= shreg_d;
      stop_idx_q <= stop_idx_d;
      tx_q       <= tx_d;
      busy_q     <= (state_d != IDLE);
      complete_q <= done;
      overflow_q <= i_wr && full_q;
      count_q    <= count_d;
      full_q     <= (count_d == CW'(DEPTH));
      empty_q    <= (count_d == '0);
      if (push) wr_ptr_q <= wr_ptr_q + FIFO_AW'(1);
      if (pop) begin
        rd_ptr_q   <= rd_ptr_q + FIFO_AW'(1);
        // Frame configuration is sampled only here, so mid-frame changes wait
        div_q      <= div_eff;
        last_idx_q <= 3'd4 + 3'(i_data_bits);
        par_en_q   <= (i_parity == 2'b01) || (i_parity == 2'b10);
        par_bit_q  <= (^head_masked) ^ (i_parity == 2'b10);
        stop2_q    <= i_stop2;
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (push) mem[wr_ptr_q] <= i_byte;
  end

  assign o_tx_serial = tx_q;
  assign o_busy      = busy_q;
  assign o_complete  = complete_q;
  assign o_overflow  = overflow_q;
  assign o_count     = count_q;
  assign o_full      = full_q;
  assign o_empty     = empty_q;

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Scoreboard bench for uart_tx_fifo: the driver queues expected frames, a
// monitor decodes the TX line cycle by cycle and checks each frame's shape.
module tb_uart_tx_fifo;
  localparam int unsigned DIV_W   = 16;
  localparam int unsigned FIFO_AW = 3;

  logic               i_clk = 1'b0;
  logic               i_rst_n = 1'b1;
  logic [DIV_W-1:0]   i_div = 16'd4;
  logic [1:0]         i_data_bits = 2'b11;
  logic [1:0]         i_parity = 2'b00;
  logic               i_stop2 = 1'b0;
  logic               i_tx_en = 1'b0;
  logic               i_wr = 1'b0;
  logic [7:0]         i_byte = 8'h00;
  logic               o_full, o_empty, o_overflow, o_busy, o_complete, o_tx_serial;
  logic [FIFO_AW:0]   o_count;

  uart_tx_fifo #(.DIV_W(DIV_W), .FIFO_AW(FIFO_AW)) dut (
    .i_clk(i_clk), .i_rst_n(i_rst_n), .i_div(i_div), .i_data_bits(i_data_bits),
    .i_parity(i_parity), .i_stop2(i_stop2), .i_tx_en(i_tx_en), .i_wr(i_wr),
    .i_byte(i_byte), .o_full(o_full), .o_empty(o_empty), .o_count(o_count),
    .o_overflow(o_overflow), .o_busy(o_busy), .o_complete(o_complete),
    .o_tx_serial(o_tx_serial)
  );

  always #5 i_clk = ~i_clk;

  int unsigned cyc = 0;
  always @(posedge i_clk) cyc <= cyc + 1;

  typedef struct {
    logic [7:0] b;
    int         div;
    int         nb;
    int         par;   // 0 none, 1 even, 2 odd
    bit         s2;
  } frame_t;

  frame_t sb[$];
  int     starts[$];
  int     total = 0;
  int     bad = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Frame as the line protocol defines it, using the current config inputs
  function automatic frame_t mk(input logic [7:0] b);
    frame_t f;
    f.b   = b;
    f.div = (i_div < 2) ? 2 : int'(i_div);
    f.nb  = 5 + int'(i_data_bits);
    f.par = (i_parity == 2'b01) ? 1 : (i_parity == 2'b10) ? 2 : 0;
    f.s2  = i_stop2;
    return f;
  endfunction

  function automatic int flen(input frame_t f);
    return f.div * (1 + f.nb + ((f.par != 0) ? 1 : 0) + (f.s2 ? 2 : 1));
  endfunction

  task automatic wr(input logic [7:0] b, input bit accept);
    @(negedge i_clk);
    i_wr   = 1'b1;
    i_byte = b;
    if (accept) sb.push_back(mk(b));
    @(posedge i_clk);
    #1;
    i_wr = 1'b0;
  endtask

  task automatic wait_drain(input int max_cyc);
    int  n;
    bit  done;
    n    = 0;
    done = 1'b0;
    while (!done && n < max_cyc) begin
      @(posedge i_clk);
      #1;
      n++;
      if (sb.size() == 0 && !o_busy && o_empty) done = 1'b1;
    end
    if (!done) chk("drain_timeout", 0, 1);
    repeat (2) @(posedge i_clk);
    #1;
  endtask

  task automatic set_cfg(input int div, input logic [1:0] db, input logic [1:0] par, input logic s2);
    @(negedge i_clk);
    i_div       = DIV_W'(div);
    i_data_bits = db;
    i_parity    = par;
    i_stop2     = s2;
  endtask

  // Monitor: a low line while not inside a frame marks a start bit
  initial begin : monitor
    frame_t f;
    logic   bits[$];
    logic   p;
    bit     abort, ok;
    forever begin
      @(posedge i_clk);
      #1;
      if (i_rst_n && o_tx_serial === 1'b0) begin
        if (sb.size() == 0) begin
          chk("unexpected_start", 0, 1);
        end else begin
          f = sb.pop_front();
          starts.push_back(int'(cyc));
          bits.delete();
          bits.push_back(1'b0);
          p = 1'b0;
          for (int i = 0; i < f.nb; i++) begin
            bits.push_back(f.b[i]);
            p = p ^ f.b[i];
          end
          if (f.par == 1) bits.push_back(p);
          if (f.par == 2) bits.push_back(~p);
          bits.push_back(1'b1);
          if (f.s2) bits.push_back(1'b1);
          chk("busy_at_start", o_busy, 1);
          abort = 1'b0;
          for (int bi = 0; bi < bits.size(); bi++) begin
            ok = 1'b1;
            for (int k = 0; k < f.div; k++) begin
              if (bi > 0 || k > 0) begin
                @(posedge i_clk);
                #1;
              end
              if (!i_rst_n) abort = 1'b1;
              if (abort) break;
              if (o_tx_serial !== bits[bi]) ok = 1'b0;
            end
            if (abort) break;
            chk($sformatf("line_bit%0d_byte%02h", bi, f.b), ok, 1);
          end
          if (!abort) begin
            @(posedge i_clk);
            #1;
            if (i_rst_n) begin
              chk($sformatf("complete_byte%02h", f.b), o_complete, 1);
              chk("busy_low_at_complete", o_busy, 0);
              chk("line_idle_after_stop", o_tx_serial, 1);
            end
          end
        end
      end
    end
  end

  initial begin : driver
    int    mcount;
    bit    acc;
    frame_t ff;
    int    len;

    #2 i_rst_n = 1'b0;
    #1;
    chk("rst_tx", o_tx_serial, 1);
    chk("rst_busy", o_busy, 0);
    chk("rst_complete", o_complete, 0);
    chk("rst_overflow", o_overflow, 0);
    chk("rst_full", o_full, 0);
    chk("rst_empty", o_empty, 1);
    chk("rst_count", o_count, 0);
    repeat (3) @(posedge i_clk);
    @(negedge i_clk) i_rst_n = 1'b1;

    // Directed frame shapes
    i_tx_en = 1'b1;
    set_cfg(4, 2'b11, 2'b00, 1'b0); wr(8'hA5, 1'b1);
    chk("count_after_first_write", o_count, 1);
    @(posedge i_clk); #1;
    chk("line_low_after_pop", o_tx_serial, 0);
    chk("busy_after_pop", o_busy, 1);
    wait_drain(500);
    set_cfg(3, 2'b10, 2'b01, 1'b1); wr(8'h83, 1'b1); wait_drain(500);
    set_cfg(3, 2'b10, 2'b10, 1'b1); wr(8'h83, 1'b1); wait_drain(500);
    set_cfg(0, 2'b00, 2'b00, 1'b0); wr(8'hFF, 1'b1); wait_drain(500);
    set_cfg(1, 2'b00, 2'b11, 1'b0); wr(8'hFF, 1'b1); wait_drain(500);

    // Config change and disable while a frame is in flight
    set_cfg(4, 2'b11, 2'b00, 1'b0);
    wr(8'h3C, 1'b1);
    wr(8'hC3, 1'b1);
    chk("count_write_with_pop", o_count, 1);
    @(negedge i_clk);
    i_tx_en = 1'b0;
    set_cfg(2, 2'b00, 2'b10, 1'b1);
    repeat (80) @(posedge i_clk);
    #1;
    chk("disabled_count", o_count, 1);
    chk("disabled_busy", o_busy, 0);
    chk("disabled_empty", o_empty, 0);
    // The held byte will be framed with the config in force at its pop
    if (sb.size() == 1) begin
      ff    = mk(sb[0].b);
      sb[0] = ff;
    end else begin
      chk("sb_depth_before_enable", sb.size(), 1);
    end
    @(negedge i_clk) i_tx_en = 1'b1;
    wait_drain(500);

    // Fill while disabled, overflow, then simultaneous pop and dropped write
    set_cfg(2, 2'b11, 2'b00, 1'b0);
    i_tx_en = 1'b0;
    mcount  = 0;
    for (int i = 0; i < 9; i++) begin
      acc = (mcount < 8);
      wr(8'(i), acc);
      if (acc) mcount++;
      chk($sformatf("fill_count%0d", i), o_count, mcount);
      chk($sformatf("fill_full%0d", i), o_full, (mcount == 8));
      chk($sformatf("fill_overflow%0d", i), o_overflow, !acc);
    end
    @(posedge i_clk); #1;
    chk("overflow_one_cycle", o_overflow, 0);
    starts.delete();
    @(negedge i_clk);
    i_tx_en = 1'b1;
    i_wr    = 1'b1;
    i_byte  = 8'h55;
    @(posedge i_clk); #1;
    i_wr = 1'b0;
    chk("pop_write_overflow", o_overflow, 1);
    chk("pop_write_count", o_count, 7);
    chk("pop_write_full", o_full, 0);
    wait_drain(1000);
    len = 2 * 10;
    chk("b2b_frames", starts.size(), 8);
    for (int i = 1; i < starts.size(); i++)
      chk($sformatf("b2b_gap%0d", i), starts[i] - starts[i-1], len + 1);
    chk("drained_empty", o_empty, 1);
    chk("drained_count", o_count, 0);

    // Randomised frames
    for (int it = 0; it < 25; it++) begin
      set_cfg(int'($urandom_range(0, 5)), 2'($urandom), 2'($urandom), 1'($urandom));
      for (int j = 0; j < int'($urandom_range(1, 4)); j++) wr(8'($urandom), 1'b1);
      wait_drain(2000);
    end

    // Reset in the middle of a data bit with bytes queued
    set_cfg(4, 2'b11, 2'b00, 1'b0);
    for (int i = 0; i < 4; i++) wr(8'hF0 + 8'(i), 1'b1);
    chk("queued_before_reset", o_count, 3);
    repeat (8) @(posedge i_clk);
    @(negedge i_clk) i_rst_n = 1'b0;
    #1;
    chk("midrst_tx", o_tx_serial, 1);
    chk("midrst_count", o_count, 0);
    chk("midrst_busy", o_busy, 0);
    chk("midrst_empty", o_empty, 1);
    sb.delete();
    repeat (3) @(posedge i_clk);
    @(negedge i_clk) i_rst_n = 1'b1;
    repeat (60) @(posedge i_clk);
    #1;
    chk("post_rst_idle_busy", o_busy, 0);
    chk("post_rst_idle_tx", o_tx_serial, 1);
    chk("post_rst_idle_empty", o_empty, 1);
    wr(8'h5A, 1'b1);
    wait_drain(500);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/uart_tx_fifo.md
# uart_tx_fifo

Parametrised UART transmitter with an integrated transmit FIFO and run-time frame configuration: 5–8 data bits, none/even/odd parity, 1 or 2 stop bits, and a programmable baud divisor. It sits between the 8051 SFR/bus write path and the TX pin, so the CPU can queue several bytes without polling per byte. It is the next-generation replacement for the fixed 8N1 transmitter.

## Interface
- DIV_W, 16: width of baud divisor (clocks per bit)
- FIFO_AW, 3: FIFO address width; depth = 2**FIFO_AW (8)
- i_clk  in  1  clock; all logic on rising edge
- i_rst_n  in  1  asynchronous, active-low reset; one clock, reset is asynchronous and active-low
- i_div  in  DIV_W  clocks per bit; values <2 are treated as 2
- i_data_bits  in  2  00=5, 01=6, 10=7, 11=8 data bits
- i_parity  in  2  00/11=none, 01=even, 10=odd
- i_stop2  in  1  0=1 stop bit, 1=2 stop bits
- i_tx_en  in  1  level enable; 0 blocks new frames, frame in flight completes
- i_wr  in  1  write strobe, one byte per high cycle
- i_byte  in  8  write data
- o_full  out  1  FIFO full
- o_empty  out  1  FIFO empty
- o_count  out  FIFO_AW+1  bytes queued (excludes frame in flight)
- o_overflow  out  1  one-cycle pulse: write dropped
- o_busy  out  1  frame in flight (state != IDLE)
- o_complete  out  1  one-cycle pulse: frame finished
- o_tx_serial  out  1  TX line, registered, idle high

## Operation
- FIFO: circular buffer, FIFO_AW-bit pointers plus count register. Write accepted iff i_wr && !o_full (status before any same-cycle pop); otherwise dropped with o_overflow pulse next cycle. Simultaneous accepted write and pop: count unchanged. Pointers wrap modulo depth.
- FSM states: IDLE, START, DATA, PARITY, STOP.
- IDLE: line 1. If i_tx_en && !o_empty: pop head, latch byte, divisor, data-bit count, parity mode, stop count into frame registers; → START.
- START: line 0 for div clocks → DATA.
- DATA: bits LSB first, bit index 0..N-1, each div clocks; bits above N-1 ignored. After bit N-1: → PARITY if parity enabled else STOP.
- PARITY: even = XOR of N data bits; odd = its inverse; div clocks → STOP.
- STOP: line 1 for div or 2·div clocks → IDLE, assert o_complete.
- Config inputs changed mid-frame take effect only at next pop.
- Bit counter: DIV_W-bit down/up counter reset at each bit boundary; each bit exactly div clocks.

## Timing
- Reset (async assert): o_tx_serial=1, o_busy=0, o_complete=0, o_overflow=0, o_full=0, o_empty=1, o_count=0, FSM=IDLE, pointers=0. Reset mid-frame aborts frame and flushes FIFO; line high immediately.
- Write at edge W with FIFO empty, FSM IDLE, enabled: o_count=1 after W; pop at W+1, o_tx_serial=0 and o_busy=1 from W+1.
- Frame length L = div·(1+N+P+S) clocks, P∈{0,1}, S∈{1,2}; start edge T → o_complete high for cycle after T+L, o_busy=0 same cycle.
- Back-to-back: next start bit at T+L+1 (exactly one idle-high clock between frames).
- i_tx_en deasserted mid-frame: frame completes; no pop while low.
- o_count/o_full/o_empty update on the edge of write/pop.

## Test plan
- div=4, 8N1, write 0xA5: line low 4 clks, then 1,0,1,0,0,1,0,1 each 4 clks, high 4 clks; o_complete at T+40; o_busy low same cycle.
- div=3, 7E2, write 0x83: data 1,1,0,0,0,0,0, parity 0, stop high 6 clks, L=33; repeat odd parity → parity bit 1.
- i_tx_en=0, write 9 bytes 0x00..0x08 back-to-back: o_full after 8th, 9th gives o_overflow pulse, o_count=8; enable → 8 frames 0x00..0x07 in order, 1-clock gaps, o_empty at end.
- Full FIFO, simultaneous pop and write: write dropped with o_overflow; o_count 8→7.
- div=0 and div=1: each bit 2 clocks; 5N1 write 0xFF → data 1,1,1,1,1, L=14.
- Assert i_rst_n=0 mid DATA with 3 bytes queued: line 1 immediately, o_count=0, o_busy=0; after release no frame until new write.
